// File: rtl/joy_db15_responder.sv
// Device side of a DB15 serial joystick link: emulates the parallel-load
// shift-register chain that an external host loads with JOY_LOAD and clocks out with JOY_CLK.
module joy_db15_responder #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FRAME_BITS  = 32,
   parameter logic IDLE_LEVEL  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] joystick1,
   input  logic [15:0] joystick2,
   input  logic        JOY_CLK,
   input  logic        JOY_LOAD,
   output logic        JOY_DATA,
   output logic        frame_done,
   output logic        overrun,
   output logic [5:0]  bit_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Bits above the frame length behave like the chain's serial-in, tied high.
   localparam logic [31:0] FRAME_MASK = 32'hFFFF_FFFF >> (32 - FRAME_BITS);
   localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS - 1);
   localparam logic [5:0]  SAT_CNT    = 6'(FRAME_BITS);

   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] load_sync_reg;
   logic                   clk_prev_reg;
   logic                   load_prev_reg;

   state_t      state_reg, state_next;
   logic [31:0] shreg_reg, shreg_next;
   logic        data_reg, data_next;
   logic [5:0]  cnt_reg, cnt_next;
   logic        done_reg, done_next;
   logic        ovr_reg, ovr_next;

   logic        clk_s, load_s;
   logic        clk_rise, load_rise, load_low;
   logic [31:0] load_word;

   // Synchronizers idle high so that reset never looks like a host edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_reg  <= '1;
         load_sync_reg <= '1;
         clk_prev_reg  <= 1'b1;
         load_prev_reg <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], JOY_CLK};
         load_sync_reg <= {load_sync_reg[SYNC_STAGES-2:0], JOY_LOAD};
         clk_prev_reg  <= clk_s;
         load_prev_reg <= load_s;
      end
   end

   assign clk_s     = clk_sync_reg[SYNC_STAGES-1];
   assign load_s    = load_sync_reg[SYNC_STAGES-1];
   assign clk_rise  = clk_s & ~clk_prev_reg;
   assign load_rise = load_s & ~load_prev_reg;
   assign load_low  = ~load_s;
   assign load_word = ~{joystick2, joystick1} | ~FRAME_MASK;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         shreg_reg <= '1;
         data_reg  <= IDLE_LEVEL;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
         ovr_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         data_reg  <= data_next;
         cnt_reg   <= cnt_next;
         done_reg  <= done_next;
         ovr_reg   <= ovr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      data_next  = data_reg;
      cnt_next   = cnt_reg;
      done_next  = 1'b0;
      ovr_next   = ovr_reg;
      case (state_reg)
         ST_IDLE: begin
            data_next = IDLE_LEVEL;
            if (load_low) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            // Parallel load is transparent: bit 0 follows the inputs while LOAD is held.
            shreg_next = load_word;
            data_next  = load_word[0];
            cnt_next   = '0;
            ovr_next   = 1'b0;
            if (load_rise) state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (load_low) begin
               state_next = ST_LOAD;
            end else if (clk_rise) begin
               if (cnt_reg == LAST_BIT) begin
                  done_next  = 1'b1;
                  data_next  = IDLE_LEVEL;
                  cnt_next   = SAT_CNT;
                  shreg_next = '1;
                  state_next = ST_DONE;
               end else begin
                  shreg_next = {1'b1, shreg_reg[31:1]};
                  data_next  = shreg_reg[1];
                  cnt_next   = cnt_reg + 6'd1;
               end
            end
         end
         ST_DONE: begin
            data_next = IDLE_LEVEL;
            if (load_low) state_next = ST_LOAD;
            else if (clk_rise) ovr_next = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign JOY_DATA   = data_reg;
   assign frame_done = done_reg;
   assign overrun    = ovr_reg;
   assign bit_cnt    = cnt_reg;

endmodule

// File: tb/tb_joy_db15_responder.sv
// Bench acting as the DB15 host: loads, clocks and samples frames, checking each
// sampled bit against the snapshot of the button words taken at load time.
module tb_joy_db15_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] joystick1 = '0;
   logic [15:0] joystick2 = '0;
   logic        JOY_CLK = 1'b0;
   logic        JOY_LOAD = 1'b1;
   logic        JOY_DATA;
   logic        frame_done;
   logic        overrun;
   logic [5:0]  bit_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   int          fd_count = 0;
   int          fd0;
   int          frame_no = 0;
   int          idx = 0;
   logic [31:0] exp_word = '0;
   logic [31:0] rd_word = '1;

   joy_db15_responder #(.SYNC_STAGES(2), .FRAME_BITS(32), .IDLE_LEVEL(1'b1)) dut (
      .clk(clk),
      .reset(reset),
      .joystick1(joystick1),
      .joystick2(joystick2),
      .JOY_CLK(JOY_CLK),
      .JOY_LOAD(JOY_LOAD),
      .JOY_DATA(JOY_DATA),
      .frame_done(frame_done),
      .overrun(overrun),
      .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   // Counts high cycles, so a stretched pulse shows up as an extra count.
   always @(negedge clk) if (frame_done === 1'b1) fd_count++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_load();
      @(negedge clk);
      JOY_LOAD = 1'b0;
      wait_clk(8);
      exp_word = {joystick2, joystick1};
      JOY_LOAD = 1'b1;
      wait_clk(8);
      idx = 0;
      rd_word = '1;
   endtask

   // Sample just before the rising edge, as a real host would.
   task automatic host_clk();
      logic exp_bit;
      exp_bit = (idx < 32) ? ~exp_word[idx] : 1'b1;
      check($sformatf("data[%0d]", idx), 32'(JOY_DATA), 32'(exp_bit));
      check($sformatf("bit_cnt[%0d]", idx), 32'(bit_cnt), (idx < 32) ? 32'(idx) : 32'd32);
      if (idx < 32) rd_word[idx] = JOY_DATA;
      JOY_CLK = 1'b1;
      wait_clk(8);
      JOY_CLK = 1'b0;
      wait_clk(8);
      idx++;
   endtask

   task automatic run_frame(input int nclk);
      host_load();
      repeat (nclk) host_clk();
      frame_no++;
      $display("frame %0d: j1=%h j2=%h clocks=%0d read=%h", frame_no, exp_word[15:0],
               exp_word[31:16], nclk, rd_word);
   endtask

   initial begin
      wait_clk(4);
      check("rst_data", 32'(JOY_DATA), 32'd1);
      check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      wait_clk(4);
      check("idle_data", 32'(JOY_DATA), 32'd1);

      // Single pressed bit at each end of the frame.
      joystick1 = 16'h0001; joystick2 = 16'h8000;
      fd0 = fd_count;
      run_frame(32);
      check("edge_bits_raw", rd_word, 32'h7FFF_FFFE);
      check("edge_frame_done", 32'(fd_count - fd0), 32'd1);
      check("edge_overrun", 32'(overrun), 32'd0);
      check("edge_bit_cnt", 32'(bit_cnt), 32'd32);
      check("edge_idle_data", 32'(JOY_DATA), 32'd1);

      joystick1 = 16'hA5A5; joystick2 = 16'h5A5A;
      run_frame(32);
      check("pattern_word", ~rd_word, 32'h5A5A_A5A5);

      // Clock past the end of the frame.
      joystick1 = 16'h00FF; joystick2 = 16'hFF00;
      run_frame(34);
      check("ovr_set", 32'(overrun), 32'd1);
      check("ovr_bit_cnt", 32'(bit_cnt), 32'd32);
      @(negedge clk);
      JOY_LOAD = 1'b0;
      wait_clk(8);
      check("ovr_cleared", 32'(overrun), 32'd0);
      check("load_bit_cnt", 32'(bit_cnt), 32'd0);
      JOY_LOAD = 1'b1;
      wait_clk(8);

      // Aborted frame followed by a full one.
      joystick1 = 16'h1234; joystick2 = 16'hABCD;
      fd0 = fd_count;
      run_frame(5);
      run_frame(32);
      check("abort_frame_done", 32'(fd_count - fd0), 32'd1);
      check("abort_word", ~rd_word, 32'hABCD_1234);

      // Inputs change mid-frame: the snapshot must hold.
      joystick1 = 16'h0000; joystick2 = 16'h0F0F;
      host_load();
      repeat (3) host_clk();
      joystick1 = 16'hFFFF;
      repeat (29) host_clk();
      frame_no++;
      $display("frame %0d: snapshot held, read=%h", frame_no, rd_word);
      check("snapshot_p1_raw", 32'(rd_word[15:0]), 32'h0000_FFFF);
      run_frame(32);
      check("next_p1_raw", 32'(rd_word[15:0]), 32'h0000_0000);

      // Asynchronous reset in the middle of a frame.
      joystick1 = 16'hFFFF; joystick2 = 16'hFFFF;
      host_load();
      repeat (9) host_clk();
      check("pre_reset_data", 32'(JOY_DATA), 32'd0);
      check("pre_reset_bit_cnt", 32'(bit_cnt), 32'd9);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_data", 32'(JOY_DATA), 32'd1);
      check("async_rst_bit_cnt", 32'(bit_cnt), 32'd0);
      wait_clk(3);
      reset = 1'b0;
      fd0 = fd_count;
      repeat (30) begin
         JOY_CLK = 1'b1;
         wait_clk(8);
         JOY_CLK = 1'b0;
         wait_clk(8);
      end
      $display("after reset: 30 host clocks without load, data=%b bit_cnt=%0d", JOY_DATA, bit_cnt);
      check("post_rst_frame_done", 32'(fd_count - fd0), 32'd0);
      check("post_rst_data", 32'(JOY_DATA), 32'd1);
      check("post_rst_bit_cnt", 32'(bit_cnt), 32'd0);
      check("post_rst_overrun", 32'(overrun), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
